// File: rtl/fft_vector_feeder.sv
// Frame store and burst sequencer: loads complex samples one lane per beat, then streams
// whole frames as LANES-wide packed vectors (lane 0 in the MSBs) with fft_start held high.
module fft_vector_feeder #(
    parameter int FORMAT_WIDTH = 9,
    parameter int LANES        = 32,
    parameter int DEPTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [FORMAT_WIDTH-1:0]         wr_real,
    input  logic [FORMAT_WIDTH-1:0]         wr_imag,
    input  logic [$clog2(DEPTH):0]          frame_count,
    input  logic                            loop_en,
    input  logic                            burst_go,
    input  logic                            burst_stop,
    input  logic                            fft_done,
    output logic                            fft_start,
    output logic [FORMAT_WIDTH*LANES-1:0]   vec_real,
    output logic [FORMAT_WIDTH*LANES-1:0]   vec_imag,
    output logic                            busy,
    output logic                            cmd_err,
    output logic [15:0]                     frames_sent
);
    localparam int FW = $clog2(DEPTH);
    localparam int CW = FW + 1;
    localparam int LW = $clog2(LANES);
    localparam int VW = FORMAT_WIDTH * LANES;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_loaded;
    logic [CW-1:0]   r_count;
    logic [LW-1:0]   r_lane;
    logic [FW-1:0]   r_next;
    logic            r_loop;
    logic            r_last;
    logic            r_done_p1;
    logic [VW-1:0]   r_mem_re [DEPTH];
    logic [VW-1:0]   r_mem_im [DEPTH];

    logic            w_idle;
    logic            w_wr;
    logic            w_go_ok;
    logic            w_wrap;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign wr_ready = w_idle && (r_loaded < CW'(DEPTH));
    assign w_wr     = wr_valid && wr_ready;
    assign w_go_ok  = (frame_count != '0) && (frame_count <= r_loaded);
    assign w_wrap   = ({1'b0, r_next} == (r_count - CW'(1)));

    // Sample store: data only, no reset; a lane is written in place within its frame word
    always_ff @(posedge clk) begin
        if (w_wr && !clr) begin
            r_mem_re[r_loaded[FW-1:0]][(LANES-1-int'(r_lane))*FORMAT_WIDTH +: FORMAT_WIDTH] <= wr_real;
            r_mem_im[r_loaded[FW-1:0]][(LANES-1-int'(r_lane))*FORMAT_WIDTH +: FORMAT_WIDTH] <= wr_imag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_loaded    <= '0;
            r_lane      <= '0;
            r_count     <= '0;
            r_next      <= '0;
            r_loop      <= 1'b0;
            r_last      <= 1'b0;
            r_done_p1   <= 1'b0;
            fft_start   <= 1'b0;
            vec_real    <= '0;
            vec_imag    <= '0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            frames_sent <= '0;
        end else begin
            cmd_err   <= 1'b0;
            r_done_p1 <= fft_done;
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_loaded <= '0;
                        r_lane   <= '0;
                        cmd_err  <= burst_go;
                    end else begin
                        if (w_wr) begin
                            if (r_lane == LW'(LANES-1)) begin
                                r_lane   <= '0;
                                r_loaded <= r_loaded + CW'(1);
                            end else begin
                                r_lane <= r_lane + LW'(1);
                            end
                        end
                        if (burst_go) begin
                            if (w_go_ok) begin
                                // First vector goes out on the accepting edge: one cycle latency
                                r_count     <= frame_count;
                                r_loop      <= loop_en;
                                r_next      <= (frame_count == CW'(1)) ? '0 : FW'(1);
                                r_last      <= !loop_en && (frame_count == CW'(1));
                                vec_real    <= r_mem_re[0];
                                vec_imag    <= r_mem_im[0];
                                fft_start   <= 1'b1;
                                frames_sent <= 16'd1;
                                busy        <= 1'b1;
                                r_state     <= S_STREAM;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                end
                S_STREAM: begin
                    if (r_last) begin
                        fft_start <= 1'b0;
                        r_state   <= S_WAIT_DONE;
                    end else begin
                        vec_real    <= r_mem_re[r_next];
                        vec_imag    <= r_mem_im[r_next];
                        frames_sent <= sat_inc16(frames_sent);
                        r_next      <= w_wrap ? '0 : r_next + FW'(1);
                        r_last      <= r_loop ? burst_stop : w_wrap;
                    end
                end
                S_WAIT_DONE: begin
                    if (r_done_p1 && !fft_done) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_vector_feeder.sv
// Scoreboard bench for fft_vector_feeder: expected vectors are queued when a burst is
// launched and compared each cycle the DUT holds fft_start high.
module tb_fft_vector_feeder;
    localparam int W  = 9;
    localparam int L  = 32;
    localparam int D  = 8;
    localparam int VW = W * L;

    logic          clk, rst, clr, wr_valid, wr_ready;
    logic [W-1:0]  wr_real, wr_imag;
    logic [3:0]    frame_count;
    logic          loop_en, burst_go, burst_stop, fft_done;
    logic          fft_start, busy, cmd_err;
    logic [VW-1:0] vec_real, vec_imag;
    logic [15:0]   frames_sent;

    fft_vector_feeder #(.FORMAT_WIDTH(W), .LANES(L), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_real(wr_real), .wr_imag(wr_imag), .frame_count(frame_count), .loop_en(loop_en),
        .burst_go(burst_go), .burst_stop(burst_stop), .fft_done(fft_done), .fft_start(fft_start),
        .vec_real(vec_real), .vec_imag(vec_imag), .busy(busy), .cmd_err(cmd_err),
        .frames_sent(frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  m_re [D][L];
    logic [W-1:0]  m_im [D][L];
    int            m_loaded, m_lane;
    logic [VW-1:0] q_re [$];
    logic [VW-1:0] q_im [$];
    int            n_vec = 0;
    logic [W-1:0]  hist [256];
    logic          sb_en;
    int            base;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_re(input int f);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[(L-1-k)*W +: W] = m_re[f][k];
        return v;
    endfunction

    function automatic logic [VW-1:0] pack_im(input int f);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[(L-1-k)*W +: W] = m_im[f][k];
        return v;
    endfunction

    task automatic push(input int f);
        q_re.push_back(pack_re(f));
        q_im.push_back(pack_im(f));
    endtask

    always @(negedge clk) begin
        if (fft_start) begin
            if (sb_en) begin
                if (q_re.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk("vec_real", vec_real, q_re.pop_front());
                    chk("vec_imag", vec_imag, q_im.pop_front());
                end
            end
            if (n_vec < 256) hist[n_vec] = vec_real[VW-1 -: W];
            n_vec++;
        end
    end

    task automatic wr_beat(input logic [W-1:0] re, input logic [W-1:0] im);
        wr_valid = 1'b1;
        wr_real  = re;
        wr_imag  = im;
        if (m_loaded < D) begin
            m_re[m_loaded][m_lane] = re;
            m_im[m_loaded][m_lane] = im;
            if (m_lane == L-1) begin
                m_lane = 0;
                m_loaded++;
            end else begin
                m_lane++;
            end
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic write_frames(input int f0, input int nf);
        for (int f = f0; f < f0 + nf; f++)
            for (int k = 0; k < L; k++)
                wr_beat(W'(k + 64*f), W'(k + 64*f + 32));
    endtask

    task automatic go(input int cnt, input logic lp);
        burst_go    = 1'b1;
        frame_count = 4'(cnt);
        loop_en     = lp;
        @(posedge clk); #1;
        burst_go = 1'b0;
        loop_en  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        m_loaded = 0;
        m_lane   = 0;
    endtask

    task automatic expect_reject(input string tag);
        @(negedge clk);
        chk({tag, "_err"}, cmd_err, 1);
        chk({tag, "_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, cmd_err, 0);
    endtask

    task automatic wait_stream_end();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); #1;
            if (!fft_start) done = 1;
        end
        if (!done) chk("stream_timeout", 0, 1);
    endtask

    task automatic finish_done();
        bit idle = 0;
        chk("wait_busy", busy, 1);
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_real = '0; wr_imag = '0;
        frame_count = '0; loop_en = 1'b0; burst_go = 1'b0; burst_stop = 1'b0; fft_done = 1'b0;
        m_loaded = 0; m_lane = 0; sb_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_frames_sent", frames_sent, 0);
        chk("rst_vec_real", vec_real, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single burst of three frames
        write_frames(0, 3);
        push(0); push(1); push(2);
        base = n_vec;
        go(3, 1'b0);
        wait_stream_end();
        chk("t1_len", n_vec - base, 3);
        chk("t1_lane0_f0", hist[base], 0);
        chk("t1_lane0_f1", hist[base+1], 64);
        chk("t1_lane0_f2", hist[base+2], 128);
        chk("t1_frames_sent", frames_sent, 3);
        chk("t1_sb_left", q_re.size(), 0);
        chk("t1_hold", vec_real, pack_re(2));
        finish_done();

        // looping burst, stop after the fifth vector
        push(0); push(1); push(0); push(1); push(0); push(1);
        base = n_vec;
        go(2, 1'b1);
        for (int i = 0; i < 50 && (n_vec - base) < 5; i++) begin
            @(negedge clk); #1;
        end
        chk("t2_reach5", n_vec - base, 5);
        burst_stop = 1'b1;
        @(posedge clk); #1;
        burst_stop = 1'b0;
        wait_stream_end();
        chk("t2_len", n_vec - base, 6);
        chk("t2_frames_sent", frames_sent, 6);
        chk("t2_sb_left", q_re.size(), 0);
        @(negedge clk);
        chk("t2_start_low", fft_start, 0);
        finish_done();

        // fill the store completely
        write_frames(3, 5);
        @(negedge clk);
        chk("t3_full_ready", wr_ready, 0);
        wr_beat(9'h1ff, 9'h1ff);
        wr_beat(9'h1ff, 9'h1ff);
        chk("t3_still_full", wr_ready, 0);
        for (int f = 0; f < D; f++) push(f);
        base = n_vec;
        go(8, 1'b0);
        wait_stream_end();
        chk("t3_len", n_vec - base, 8);
        chk("t3_frames_sent", frames_sent, 8);
        finish_done();

        // rejected commands
        go(0, 1'b0);
        expect_reject("t4_cnt0");
        clr = 1'b1;
        go(1, 1'b0);
        clr = 1'b0;
        m_loaded = 0; m_lane = 0;
        expect_reject("t4_clr_go");
        go(1, 1'b0);
        expect_reject("t4_empty");
        write_frames(0, 3);
        go(4, 1'b0);
        expect_reject("t4_cnt4");
        push(0); push(1); push(2);
        base = n_vec;
        go(3, 1'b0);
        wait_stream_end();
        chk("t4_len", n_vec - base, 3);
        finish_done();

        // clr discards a partial frame
        do_clr();
        for (int i = 0; i < 40; i++) wr_beat(W'(300 + i), W'(400 + i));
        do_clr();
        for (int k = 0; k < L; k++) wr_beat(W'(100 + k), W'(200 + k));
        go(2, 1'b0);
        expect_reject("t6_two");
        push(0);
        base = n_vec;
        go(1, 1'b0);
        wait_stream_end();
        chk("t6_len", n_vec - base, 1);
        chk("t6_sb_left", q_re.size(), 0);
        finish_done();

        // reset in the middle of a looping burst
        sb_en = 1'b0;
        go(1, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_fft_start", fft_start, 0);
        chk("t5_busy", busy, 0);
        chk("t5_vec_real", vec_real, 0);
        chk("t5_vec_imag", vec_imag, 0);
        chk("t5_frames_sent", frames_sent, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_loaded = 0; m_lane = 0;
        @(negedge clk);
        chk("t5_wr_ready", wr_ready, 1);
        go(1, 1'b0);
        expect_reject("t5_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
